// File: rtl/button_conditioner.sv
// Per-channel button/switch conditioner: polarity fix, 2-flop synchroniser, debounce FSM,
// registered press/release strobes and a press-toggled state bit.
module button_conditioner #(
    parameter int unsigned          Channels    = 5,
    parameter int unsigned          Clock_freq  = 50000000,
    parameter int unsigned          Debounce_ms = 10,
    parameter logic [Channels-1:0]  Active_low  = {Channels{1'b1}},
    parameter logic [Channels-1:0]  Toggle_init = Channels'(5'b01000)
) (
    input  logic                i_clock_50mhz,
    input  logic                i_reset,
    input  logic [Channels-1:0] i_raw,
    input  logic                i_toggle_clear,
    output logic [Channels-1:0] o_level,
    output logic [Channels-1:0] o_press,
    output logic [Channels-1:0] o_release,
    output logic [Channels-1:0] o_toggle
);

    localparam int unsigned lp_debounce_cycles = Clock_freq / 1000 * Debounce_ms;
    localparam int unsigned CntW = (lp_debounce_cycles > 2) ? $clog2(lp_debounce_cycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(lp_debounce_cycles - 1);

    if (lp_debounce_cycles < 2) begin : gen_bad_debounce
        $error("button_conditioner: debounce time must be at least 2 clock cycles");
    end
    if (Channels < 1 || Channels > 16) begin : gen_bad_channels
        $error("button_conditioner: Channels must be in 1..16");
    end

    typedef enum logic {StStable, StPending} state_e;

    for (genvar g = 0; g < Channels; g++) begin : gen_ch
        state_e          state_q;
        logic [CntW-1:0] cnt_q;
        logic            sync1_q;
        logic            sync2_q;
        logic            level_q;
        logic            press_q;
        logic            release_q;
        logic            toggle_q;

        always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
            if (!i_reset) begin
                state_q   <= StStable;
                cnt_q     <= '0;
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                toggle_q  <= Toggle_init[g];
            end else begin
                sync1_q   <= i_raw[g] ^ Active_low[g];
                sync2_q   <= sync1_q;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state_q)
                    StStable: begin
                        if (sync2_q != level_q) begin
                            state_q <= StPending;
                            cnt_q   <= CntW'(1);
                        end
                    end
                    StPending: begin
                        if (sync2_q == level_q) begin
                            state_q <= StStable;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            // Input held its new value for the full window: commit it.
                            state_q   <= StStable;
                            cnt_q     <= '0;
                            level_q   <= sync2_q;
                            press_q   <= sync2_q;
                            release_q <= ~sync2_q;
                            if (sync2_q) begin
                                toggle_q <= ~toggle_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end
                endcase
                // Clear takes priority over a coincident press; the strobe still fires.
                if (i_toggle_clear) begin
                    toggle_q <= Toggle_init[g];
                end
            end
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_toggle[g]  = toggle_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner; a run-length reference model feeds a
// per-cycle expectation queue that an independent monitor drains.
module tb_button_conditioner;

    localparam int unsigned Ch = 5;
    localparam int unsigned N  = 5;
    localparam logic [Ch-1:0] Al = 5'b00001;
    localparam logic [Ch-1:0] Ti = 5'b01000;
    localparam logic [Ch-1:0] Idle = Al;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [Ch-1:0] raw = Idle;
    logic          clr = 1'b0;
    logic [Ch-1:0] o_level, o_press, o_release, o_toggle;

    always #5 clk = ~clk;

    button_conditioner #(
        .Channels    (Ch),
        .Clock_freq  (1000),
        .Debounce_ms (5),
        .Active_low  (Al),
        .Toggle_init (Ti)
    ) dut (
        .i_clock_50mhz  (clk),
        .i_reset        (rst_n),
        .i_raw          (raw),
        .i_toggle_clear (clr),
        .o_level        (o_level),
        .o_press        (o_press),
        .o_release      (o_release),
        .o_toggle       (o_toggle)
    );

    typedef struct packed {
        logic [Ch-1:0] level;
        logic [Ch-1:0] press;
        logic [Ch-1:0] rel;
        logic [Ch-1:0] tog;
    } snap_t;

    snap_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    // Reference: a channel commits a new level once the synchronised input has disagreed with
    // it for N consecutive samples; the synchronised input lags the raw sample by two edges.
    logic [Ch-1:0] m_level = '0;
    logic [Ch-1:0] m_tog = Ti;
    int            m_run[Ch];
    logic [Ch-1:0] m_hist[$];

    task automatic chk(input string name, input logic [Ch-1:0] got, input logic [Ch-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %b expected %b", name, cyc, got, want);
        end
    endtask

    task automatic model_edge(input logic [Ch-1:0] r, input logic c, input logic rn);
        snap_t         s;
        logic [Ch-1:0] seen;
        s.press = '0;
        s.rel   = '0;
        if (!rn) begin
            m_level = '0;
            m_tog   = Ti;
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
            foreach (m_run[i]) m_run[i] = 0;
        end else begin
            seen = m_hist.pop_front();
            m_hist.push_back(r ^ Al);
            for (int ch = 0; ch < Ch; ch++) begin
                if (seen[ch] != m_level[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == N) begin
                        m_level[ch] = seen[ch];
                        if (seen[ch]) s.press[ch] = 1'b1;
                        else          s.rel[ch]   = 1'b1;
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_tog = c ? Ti : (m_tog ^ s.press);
        end
        s.level = m_level;
        s.tog   = m_tog;
        exp_q.push_back(s);
    endtask

    task automatic step(input logic [Ch-1:0] r, input logic c, input logic rn);
        @(posedge clk);
        #2;
        raw   = r;
        clr   = c;
        rst_n = rn;
        model_edge(r, c, rn);
        cyc++;
    endtask

    task automatic hold(input logic [Ch-1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("level", o_level, s.level);
                chk("press", o_press, s.press);
                chk("release", o_release, s.rel);
                chk("toggle", o_toggle, s.tog);
            end
        end
    end

    initial begin : driver
        logic [Ch-1:0] cur;
        int            bounce[11];
        bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};

        // Reset asserted with ch0 held pressed (active-low).
        raw = 5'b00000;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_level", o_level, '0);
        chk("reset_press", o_press, '0);
        chk("reset_release", o_release, '0);
        chk("reset_toggle", o_toggle, Ti);
        for (int i = 0; i < 3; i++) step(5'b00000, 1'b0, 1'b0);
        hold(5'b00000, 10);
        hold(Idle, 10);

        // Clean press/release on ch1.
        hold(Idle | 5'b00010, 20);
        hold(Idle, 10);

        // Bounce on ch2.
        foreach (bounce[i]) step(Idle | (bounce[i] ? 5'b00100 : 5'b00000), 1'b0, 1'b1);
        hold(Idle | 5'b00100, 10);
        hold(Idle, 10);

        // Toggle on ch3, clear coinciding with the fourth press.
        for (int k = 0; k < 3; k++) begin
            hold(Idle | 5'b01000, 10);
            hold(Idle, 10);
        end
        hold(Idle | 5'b01000, 6);
        step(Idle | 5'b01000, 1'b1, 1'b1);
        hold(Idle | 5'b01000, 8);
        hold(Idle, 10);

        // Reset while ch4 is mid-debounce.
        hold(Idle | 5'b10000, 5);
        step(Idle | 5'b10000, 1'b0, 1'b0);
        hold(Idle | 5'b10000, 10);
        hold(Idle, 10);

        // Simultaneous ch1/ch2.
        hold(Idle | 5'b00110, 10);
        hold(Idle, 10);

        // Random bouncy activity with occasional clear and reset.
        cur = Idle;
        for (int i = 0; i < 2000; i++) begin
            for (int ch = 0; ch < Ch; ch++) begin
                if ($urandom_range(0, 9) == 0) cur[ch] = ~cur[ch];
            end
            step(cur, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) != 0));
        end
        hold(Idle, 10);

        @(posedge clk);
        #3;
        chk("drained", 5'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of top_entity.
- Takes raw, bouncy push-button and slide-switch levels from the board and delivers clean per-channel signals to the counter's control inputs (set, reset, pause, count direction, type):
  - debounced level
  - single-cycle press and release strobes
  - a press-toggled state bit
- Channels are independent and identical apart from per-channel polarity and toggle reset value.

Parameters:
- Channels, 5, number of independent input channels (1..16).
- Clock_freq, 50000000, clock frequency in Hz.
- Debounce_ms, 10, required stable time in ms. Derived lp_debounce_cycles = Clock_freq/1000*Debounce_ms. Must be >= 2 (elaboration error otherwise).
- Active_low, 5'b11111, per-channel polarity mask. Bit=1 means the raw input is pressed when 0, and the channel is inverted before synchronisation.
- Toggle_init, 5'b01000, per-channel reset value of o_toggle.

Ports:
- i_clock_50mhz  input  1  system clock, all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_raw  input  Channels  raw asynchronous button/switch levels.
- i_toggle_clear  input  1  synchronous clear of all o_toggle bits to Toggle_init.
- o_level  output  Channels  debounced, polarity-corrected level (1 = pressed/on).
- o_press  output  Channels  one-cycle strobe on debounced 0->1.
- o_release  output  Channels  one-cycle strobe on debounced 1->0.
- o_toggle  output  Channels  flips on each o_press.

Behaviour:
- Reset (i_reset=0, asynchronous assert, synchronous-to-clock deassert handled by the caller):
  - o_level=0, o_press=0, o_release=0, o_toggle=Toggle_init.
  - Both sync flops and the debounce counters cleared to 0, i.e. the inactive level after polarity correction.
  - No strobe may fire in the cycle after reset release, even if a button is held. A held button produces o_press only after the full debounce time.
- Per channel:
  - Polarity XOR with Active_low bit.
  - Then a 2-flop synchroniser (sync1, sync2).
  - Then a debounce FSM with counter width $clog2(lp_debounce_cycles).
- FSM states:
  - STABLE: sync2 == o_level; counter held at 0.
  - STABLE -> PENDING: when sync2 != o_level; counter loads 1.
  - PENDING:
    - if sync2 == o_level, return to STABLE and clear the counter (glitch rejected, no output change);
    - else counter+1.
  - PENDING -> STABLE: when sync2 != o_level and counter == lp_debounce_cycles-1. On that edge o_level flips and exactly one of o_press/o_release is 1 for one cycle.
- Latency:
  - First rising edge that samples a clean raw change = E.
  - o_level and the strobe update at edge E+1+lp_debounce_cycles.
  - Any deviation lasting fewer than lp_debounce_cycles consecutive samples at sync2 is ignored.
- Strobes are registered outputs, 0 in every cycle except the update edge. o_press and o_release are never both 1 on one channel.
- o_toggle[n] flips on the same edge o_press[n] rises.
- i_toggle_clear=1:
  - o_toggle is set to Toggle_init on the next edge.
  - Clear wins over a simultaneous press. The press strobe itself still fires.
  - o_level is not affected.
- Counter never wraps: it saturates by construction because PENDING exits at lp_debounce_cycles-1.
- Reset mid-PENDING aborts the pending change. No strobe is produced.
- Channels do not interact. Simultaneous transitions on several channels each behave as if alone.

Test Plan:
Common setup: Clock_freq=1000, Debounce_ms=5 (lp_debounce_cycles=5), Channels=5, Active_low=5'b00001, Toggle_init=5'b01000.
- Reset check: hold i_reset=0 with i_raw[0]=0 (pressed, active-low).
  - Immediately: o_level=0, o_toggle=5'b01000, no strobes.
  - After i_reset=1: o_press[0] pulses once at edge E+6 after the first sampling edge, o_level[0]=1.
- Clean press/release ch1: i_raw[1] 0->1, held 20 cycles, then 1->0.
  - o_press[1] is a single-cycle pulse 6 edges after capture.
  - o_release[1] is a single-cycle pulse 6 edges after the release capture.
  - o_level[1] high for 20 cycles.
- Bounce rejection ch2: i_raw[2] pattern 1,0,1,1,0,1,1,1,1,1,1 (1 cycle each).
  - Exactly one o_press[2], occurring 6 edges after the start of the final 1-run.
  - Glitches of 1–4 cycles give no strobe.
- Toggle: press/release ch3 three times.
  - o_toggle[3] sequence 1->0->1->0.
  - Assert i_toggle_clear on the same edge as the 4th press: o_toggle[3]=1 (Toggle_init) and o_press[3] still pulses.
- Reset mid-debounce: i_raw[4] 0->1, i_reset=0 for 1 cycle at counter=3, i_raw[4] kept 1.
  - No strobe before reset.
  - After release, o_press[4] fires a full 6 edges after the new capture.
- Parallel channels: ch1 and ch2 rise on the same cycle.
  - Both o_press strobes on the identical edge; other channels unchanged.
